// File: rtl/alu_result_display.sv
// Double-dabble binary-to-BCD of an ALU result (2*WIDTH cycles, start taken only when ready; no queueing)
// plus a registered, free-running multiplexed 7-segment scan with leading-zero blanking and overflow dashes.
module alu_result_display #(
  parameter int WIDTH       = 4,
  parameter int NDIG        = 3,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                 clk,
  input  logic                 arst,
  input  logic                 start,
  input  logic [2*WIDTH-1:0]   value,
  output logic                 ready,
  output logic                 done,
  output logic [4*NDIG-1:0]    bcd,
  output logic                 ovf,
  output logic [NDIG-1:0]      an,
  output logic [6:0]           seg
);

  function automatic int dec_digits(input int bits);
    longint m;
    int     n;
    m = (longint'(1) << bits) - 1;
    n = 1;
    for (int i = 0; i < 20; i++) begin
      if (m >= 10) begin
        m = m / 10;
        n = n + 1;
      end
    end
    return n;
  endfunction

  function automatic logic [6:0] seg_enc(input logic [3:0] d);
    case (d)
      4'd0:    seg_enc = 7'b1000000;
      4'd1:    seg_enc = 7'b1111001;
      4'd2:    seg_enc = 7'b0100100;
      4'd3:    seg_enc = 7'b0110000;
      4'd4:    seg_enc = 7'b0011001;
      4'd5:    seg_enc = 7'b0010010;
      4'd6:    seg_enc = 7'b0000010;
      4'd7:    seg_enc = 7'b1111000;
      4'd8:    seg_enc = 7'b0000000;
      4'd9:    seg_enc = 7'b0010000;
      default: seg_enc = 7'b1111111;
    endcase
  endfunction

  localparam int VW  = 2 * WIDTH;
  localparam int FD  = dec_digits(VW);
  // Scratch always holds every decimal digit of the largest input, so overflow is visible.
  localparam int SD  = (FD > NDIG) ? FD : NDIG;
  localparam int CW  = $clog2(VW + 1);
  localparam int SCW = $clog2(REFRESH_DIV);
  localparam int IW  = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic {IDLE, CONV} state_t;

  state_t            state, state_nxt;
  logic [1:0]        rst_sync;
  logic              run;
  logic [4*SD-1:0]   scr, scr_adj, scr_nxt;
  logic [VW-1:0]     shf;
  logic [CW-1:0]     cnt;
  logic              last_step;
  logic              ovf_nxt;
  logic [SCW-1:0]    scan_cnt;
  logic [IW-1:0]     idx;
  logic [3:0]        digit;
  logic              upper_nz;
  logic [6:0]        seg_nxt;
  logic [NDIG-1:0]   an_nxt;

  // Release is synchronised; state only moves once run is high.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) rst_sync <= 2'b00;
    else       rst_sync <= {rst_sync[0], 1'b1};
  end
  assign run = rst_sync[1];

  assign ready     = (state == IDLE);
  assign last_step = (cnt == CW'(VW - 1));

  always_ff @(posedge clk or negedge arst) begin
    if (!arst)    state <= IDLE;
    else if (run) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start)     state_nxt = CONV;
      CONV: if (last_step) state_nxt = IDLE;
      default:             state_nxt = IDLE;
    endcase
  end

  always_comb begin
    scr_adj = scr;
    for (int i = 0; i < SD; i++) begin
      if (scr[4*i +: 4] >= 4'd5) scr_adj[4*i +: 4] = scr[4*i +: 4] + 4'd3;
    end
    scr_nxt = {scr_adj[4*SD-2:0], shf[VW-1]};
  end

  generate
    if (SD > NDIG) begin : g_ovf
      assign ovf_nxt = |scr_nxt[4*SD-1:4*NDIG];
    end else begin : g_no_ovf
      assign ovf_nxt = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      scr  <= '0;
      shf  <= '0;
      cnt  <= '0;
      bcd  <= '0;
      ovf  <= 1'b0;
      done <= 1'b0;
    end else if (run) begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          shf <= value;
          scr <= '0;
          cnt <= '0;
        end
        CONV: begin
          scr <= scr_nxt;
          shf <= shf << 1;
          cnt <= cnt + CW'(1);
          if (last_step) begin
            bcd  <= scr_nxt[4*NDIG-1:0];
            ovf  <= ovf_nxt;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else if (run) begin
      if (scan_cnt == SCW'(REFRESH_DIV - 1)) begin
        scan_cnt <= '0;
        idx      <= (idx == IW'(NDIG - 1)) ? '0 : idx + IW'(1);
      end else begin
        scan_cnt <= scan_cnt + SCW'(1);
      end
    end
  end

  // A digit above the units is blank when it and all higher digits are zero.
  always_comb begin
    digit    = 4'd0;
    upper_nz = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (IW'(i) == idx) digit = bcd[4*i +: 4];
      if (IW'(i) >= idx && bcd[4*i +: 4] != 4'd0) upper_nz = 1'b1;
    end
    if (ovf)                          seg_nxt = 7'b0111111;
    else if (idx != '0 && !upper_nz)  seg_nxt = 7'b1111111;
    else                              seg_nxt = seg_enc(digit);
    an_nxt = ~(NDIG'(1) << idx);
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      an  <= ~NDIG'(1);
      seg <= 7'b1000000;
    end else if (run) begin
      an  <= an_nxt;
      seg <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_alu_result_display.sv
// Bench for alu_result_display: vector table and scoreboard on a 3-digit instance,
// overflow behaviour on a 2-digit instance, plus scan, reset-abort and back-to-back sequences.
module tb_alu_result_display;

  logic        clk = 1'b0;
  logic        arst, start, start2;
  logic [7:0]  value, value2;
  logic        ready, done, ovf, ready2, done2, ovf2;
  logic [11:0] bcd;
  logic [7:0]  bcd2;
  logic [2:0]  an;
  logic [1:0]  an2;
  logic [6:0]  seg, seg2;

  alu_result_display #(.WIDTH(4), .NDIG(3), .REFRESH_DIV(4)) dut (
    .clk(clk), .arst(arst), .start(start), .value(value), .ready(ready), .done(done),
    .bcd(bcd), .ovf(ovf), .an(an), .seg(seg));

  alu_result_display #(.WIDTH(4), .NDIG(2), .REFRESH_DIV(4)) dut2 (
    .clk(clk), .arst(arst), .start(start2), .value(value2), .ready(ready2), .done(done2),
    .bcd(bcd2), .ovf(ovf2), .an(an2), .seg(seg2));

  always #5 clk = ~clk;

  typedef struct { logic [11:0] bcd; logic ovf; } exp_t;
  typedef struct { logic [7:0] v; logic [11:0] bcd; logic ovf; } vec_t;

  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  int    prev_done = 0;
  bit    period_chk = 0;
  bit    have_prev = 0;
  exp_t  exp_q[$];
  exp_t  mon_e;
  vec_t  tbl[7];

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input int v, input int nd);
    exp_t e;
    int   x;
    x     = v;
    e.bcd = '0;
    for (int i = 0; i < nd; i++) begin
      e.bcd[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    e.ovf = (x != 0);
    return e;
  endfunction

  // Scoreboard: each done pops the result expected for the oldest accepted start.
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending conversion (t=%0t)", $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_bcd", bcd, mon_e.bcd);
        check("sb_ovf", ovf, mon_e.ovf);
      end
      if (period_chk && have_prev) check("done_period", cyc - prev_done, 9);
      have_prev = 1;
      prev_done = cyc;
    end
  end

  task automatic check_reset();
    check("rst_ready", ready, 1);
    check("rst_done", done, 0);
    check("rst_bcd", bcd, 0);
    check("rst_ovf", ovf, 0);
    check("rst_an", an, 3'b110);
    check("rst_seg", seg, 7'b1000000);
  endtask

  // Called at a negedge; returns at the negedge where done is seen.
  task automatic run1(input logic [7:0] v, output int lat, output bit got);
    int tmo;
    tmo = 0;
    while (!ready && tmo < 20) begin @(negedge clk); tmo++; end
    value = v;
    start = 1'b1;
    exp_q.push_back(model(v, 3));
    @(posedge clk);
    #1;
    start = 1'b0;
    value = 8'($urandom);
    lat = 0;
    got = 0;
    for (int k = 0; k < 30 && !got; k++) begin
      @(negedge clk);
      if (done) got = 1;
      else if (!ready) lat++;
    end
    if (!got) check("done_timeout", 0, 1);
  endtask

  task automatic run2(input logic [7:0] v, output bit got);
    value2 = v;
    start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    value2 = 8'($urandom);
    got = 0;
    for (int k = 0; k < 30 && !got; k++) begin
      @(negedge clk);
      if (done2) got = 1;
    end
    if (!got) check("done2_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int         lat, tmo, ndone;
    bit         got, found;
    logic [2:0] prev_an;
    logic [2:0] slot_an[3];
    logic [6:0] slot_seg[3];

    tbl[0] = '{8'd255, 12'h255, 1'b0};
    tbl[1] = '{8'd0,   12'h000, 1'b0};
    tbl[2] = '{8'd10,  12'h010, 1'b0};
    tbl[3] = '{8'd99,  12'h099, 1'b0};
    tbl[4] = '{8'd128, 12'h128, 1'b0};
    tbl[5] = '{8'd200, 12'h200, 1'b0};
    tbl[6] = '{8'd7,   12'h007, 1'b0};
    slot_an[0] = 3'b110; slot_seg[0] = 7'b1111000;
    slot_an[1] = 3'b101; slot_seg[1] = 7'b1111111;
    slot_an[2] = 3'b011; slot_seg[2] = 7'b1111111;

    arst = 1'b0; start = 1'b0; value = '0; start2 = 1'b0; value2 = '0;
    repeat (3) @(negedge clk);
    check_reset();
    arst = 1'b1;
    repeat (4) @(negedge clk);
    check("post_release_bcd", bcd, 0);

    for (int i = 0; i < 7; i++) begin
      run1(tbl[i].v, lat, got);
      check("latency", lat, 8);
      check("vec_bcd", bcd, tbl[i].bcd);
      check("vec_ovf", ovf, tbl[i].ovf);
      @(negedge clk);
      check("done_single", done, 0);
    end

    // Scan of 7: units shows '7', tens and hundreds blank, 4 cycles each.
    repeat (2) @(negedge clk);
    prev_an = an;
    found = 0;
    tmo = 0;
    while (!found && tmo < 40) begin
      @(negedge clk);
      tmo++;
      if (an == 3'b110 && prev_an != 3'b110) found = 1;
      prev_an = an;
    end
    check("scan_sync", found, 1);
    for (int s = 0; s < 3; s++) begin
      for (int c = 0; c < 4; c++) begin
        if (s != 0 || c != 0) @(negedge clk);
        check("scan_an", an, slot_an[s]);
        check("scan_seg", seg, slot_seg[s]);
      end
    end

    // start held during CONV is ignored and not queued.
    @(negedge clk);
    value = 8'd123;
    start = 1'b1;
    exp_q.push_back(model(123, 3));
    @(posedge clk);
    #1 value = 8'd45;
    repeat (3) @(posedge clk);
    #1 start = 1'b0;
    ndone = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("ignore_start_dones", ndone, 1);
    check("ignore_start_bcd", bcd, 12'h123);

    // Overflow on the 2-digit instance.
    run2(8'd100, got);
    check("ovf2_flag", ovf2, 1);
    check("ovf2_bcd", bcd2, 8'h00);
    repeat (2) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      check("ovf2_seg", seg2, 7'b0111111);
      @(negedge clk);
    end
    run2(8'd99, got);
    check("nd2_flag", ovf2, 0);
    check("nd2_bcd", bcd2, 8'h99);

    // start held high, value stepping through every code.
    @(negedge clk);
    have_prev  = 0;
    period_chk = 1;
    start = 1'b1;
    for (int v = 0; v < 256; v++) begin
      value = 8'(v);
      tmo = 0;
      while (!ready && tmo < 20) begin @(negedge clk); tmo++; end
      if (!ready) check("stream_ready_timeout", 0, 1);
      exp_q.push_back(model(v, 3));
      @(negedge clk);
    end
    start = 1'b0;
    tmo = 0;
    while (exp_q.size() != 0 && tmo < 30) begin @(negedge clk); tmo++; end
    check("stream_drain", exp_q.size(), 0);
    period_chk = 0;
    repeat (2) @(negedge clk);

    // Reset in the middle of converting 200 aborts it.
    value = 8'd200;
    start = 1'b1;
    exp_q.push_back(model(200, 3));
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 arst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check_reset();
    @(negedge clk);
    arst = 1'b1;
    ndone = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort_no_done", ndone, 0);
    run1(8'd42, lat, got);
    check("after_rst_latency", lat, 8);
    check("after_rst_bcd", bcd, 12'h042);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_result_display.md
ALU_RESULT_DISPLAY -- requirements
Module: alu_result_display

Interface
REQ-001 Parameter WIDTH, default 4: ALU operand width. The result input is 2*WIDTH bits.
REQ-002 Parameter NDIG, default 3: number of decimal digits converted and displayed, NDIG >= 1.
REQ-003 Parameter REFRESH_DIV, default 50000: clk cycles per displayed digit slot, REFRESH_DIV >= 2.
REQ-004 clk  in  1: rising-edge clock for all state.
REQ-005 arst  in  1: reset, asynchronous, active-low.
REQ-006 start  in  1: request to convert `value`. Sampled only when ready=1.
REQ-007 value  in  2*WIDTH: unsigned ALU result (alu_out) to be converted.
REQ-008 ready  out  1: high when idle and able to accept start.
REQ-009 done  out  1: single-cycle pulse marking that bcd/ovf have just been updated.
REQ-010 bcd  out  4*NDIG: registered BCD result. Digit 0 (units) is in bits [3:0].
REQ-011 ovf  out  1: registered; high when the last converted value exceeded 10^NDIG-1.
REQ-012 an  out  NDIG: digit enables, active-low, one-hot-low.
REQ-013 seg  out  7: segment drive, active-low, seg[6:0]={g,f,e,d,c,b,a}.

Function
REQ-014 The FSM SHALL have exactly two states, IDLE and CONV, and ready SHALL be 1 exactly when the state is IDLE.
REQ-015 In IDLE, start=1 at edge E0 SHALL capture value into the shift register, clear the BCD scratch register and iteration counter, and enter CONV.
REQ-016 In CONV, each edge SHALL perform one double-dabble step: add 3 to every scratch digit >= 5, then shift {scratch, shift} left by 1.
REQ-017 After exactly 2*WIDTH steps (edges E1..E2W), at edge E2W the FSM SHALL load bcd from the final scratch, load ovf, assert done for one cycle, and return to IDLE.
REQ-018 Latency from start to done is therefore 2*WIDTH cycles. A new start is accepted on the cycle done is high, giving back-to-back throughput of one conversion per 2*WIDTH+1 cycles.
REQ-019 start while in CONV SHALL be ignored; it is not queued, and the value being converted is unaffected.
REQ-020 value changes after E0 SHALL NOT affect the conversion in progress.
REQ-021 The scratch register SHALL be wide enough to hold the full decimal result of 2^(2*WIDTH)-1. ovf SHALL be 1 when any digit above NDIG-1 is non-zero, and bcd SHALL then hold the low NDIG digits.
REQ-022 bcd and ovf SHALL hold their last values during CONV and in IDLE; only REQ-017 updates them.
REQ-023 The scan counter SHALL count 0..REFRESH_DIV-1 and wrap. On each wrap, the digit index SHALL advance 0..NDIG-1 and wrap to 0.
REQ-024 an SHALL drive bit [index] low and all other bits high.
REQ-025 seg encoding for digits 0-9 SHALL use standard active-low patterns; '0' = 7'b1000000 and '8' = 7'b0000000.
REQ-026 Leading-zero blanking: a digit with index > 0 SHALL show blank (7'b1111111) when it and every higher digit are zero. Digit 0 is never blanked.
REQ-027 When ovf=1, every digit SHALL show '-' (7'b0111111).
REQ-028 BCD codes 10-15 cannot occur. If they do, the display SHALL show blank.
REQ-029 The scan logic SHALL run independently of the FSM, and display SHALL be glitch-free across a bcd update: an and seg SHALL be registered.

Reset
REQ-030 arst=0 SHALL asynchronously force: state=IDLE, ready=1, done=0, bcd=0, ovf=0, scratch/shift/counter=0, scan counter=0, index=0, an={all 1, bit0=0}, seg=7'b1000000.
REQ-031 Reset asserted mid-CONV SHALL abort the conversion with no done pulse. After release, the module is idle, and the first accepted start behaves per REQ-015.
REQ-032 Reset release SHALL be synchronised internally; the first active edge after release performs no state change.

Verification
REQ-033 WIDTH=4, NDIG=3, value=8'd255, start pulse -> done exactly 8 cycles later, bcd=12'h255, ovf=0, ready low for 8 cycles.
REQ-034 value=8'd7 -> bcd=12'h007. With REFRESH_DIV=4, the scan shows an=110 seg='7' (7'b1111000), then an=101 blank, then an=011 blank, each for 4 cycles.
REQ-035 NDIG=2, value=8'd100 -> ovf=1, bcd=8'h00, all digits show 7'b0111111. Next, value=8'd99 -> ovf=0, bcd=8'h99.
REQ-036 start held high continuously with value stepping 0..255 -> done every 9 cycles, and each bcd equals the decimal of the value sampled at acceptance. The bench checks all 256 values.
REQ-037 Pulse arst low at cycle 4 of a conversion of 8'd200 -> no done pulse, all outputs at REQ-030 values. A following conversion of 8'd42 yields bcd=12'h042.
